// File: rtl/distribute_1x2_cmd_sched.sv
// distribute_1x2_cmd_sched
// Command scheduler and one-beat output buffer in front of distribute_1x2_simple_comb.
// A FIFO of routing commands (drop/low/high/duplicate, each with a repeat count) selects the
// destination of every accepted upstream beat. The buffered beat is retired per branch, so a
// duplicate beat can finish on one branch while it waits on the other.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; valid
// never depends on ready of the same interface.
//
// Optional feature: define DIST_SCHED_PERF_CNT_EN to add saturating 16-bit counters
// o_cnt_low, o_cnt_high and o_cnt_stall.
//
// o_dbg_state exposes the control state: 0 IDLE, 1 ARMED, 2 BUSY.
module distribute_1x2_cmd_sched #(
    parameter int DATA_WIDTH     = 32,
    parameter int COMMAND_WIDTH  = 2,
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int RPT_WIDTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cfg_valid,
    output logic                     o_cfg_ready,
    input  logic [COMMAND_WIDTH-1:0] i_cfg_cmd,
    input  logic [RPT_WIDTH-1:0]     i_cfg_rpt,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DATA_WIDTH-1:0]    i_data_bus,
    output logic                     o_sw_en,
    output logic                     o_sw_valid,
    output logic [COMMAND_WIDTH-1:0] o_sw_cmd,
    output logic [DATA_WIDTH-1:0]    o_data_bus,
    input  logic [1:0]               i_ready,
    output logic                     o_busy,
`ifdef DIST_SCHED_PERF_CNT_EN
    output logic [15:0]              o_cnt_low,
    output logic [15:0]              o_cnt_high,
    output logic [15:0]              o_cnt_stall,
`endif
    output logic [1:0]               o_dbg_state
);

    localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    // Command FIFO storage and pointers
    logic [COMMAND_WIDTH-1:0] fifo_cmd_q [CMD_FIFO_DEPTH];
    logic [RPT_WIDTH-1:0]     fifo_rpt_q [CMD_FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         count_q, count_d;

    // Active command and beat buffer
    logic                     act_valid_q, act_valid_d;
    logic [COMMAND_WIDTH-1:0] act_cmd_q, act_cmd_d;
    logic [RPT_WIDTH-1:0]     act_cnt_q, act_cnt_d;
    logic                     buf_valid_q, buf_valid_d;
    logic [COMMAND_WIDTH-1:0] buf_cmd_q, buf_cmd_d;
    logic [DATA_WIDTH-1:0]    buf_data_q, buf_data_d;
    logic [1:0]               served_q, served_d;
    state_e                   state_q, state_d;

    logic fifo_full, fifo_empty, push, pop, accept, act_last, buf_done;
    logic [1:0] sw_cmd, acc;

    // Handshake and retirement decode
    always_comb begin
        fifo_full  = (count_q == CNT_W'(CMD_FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        sw_cmd     = buf_valid_q ? (buf_cmd_q & ~served_q) : 2'b00;
        acc        = sw_cmd & i_ready;
        buf_done   = buf_valid_q & ((sw_cmd & ~i_ready) == 2'b00);
        o_ready    = act_valid_q & (!buf_valid_q | buf_done);
        accept     = i_valid & o_ready;
        act_last   = accept & (act_cnt_q == '0);
        pop        = !fifo_empty & (!act_valid_q | act_last);
        push       = i_cfg_valid & !fifo_full;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Next active command and next buffer contents
    always_comb begin
        act_valid_d = act_valid_q;
        act_cmd_d   = act_cmd_q;
        act_cnt_d   = act_cnt_q;
        buf_valid_d = buf_valid_q;
        buf_cmd_d   = buf_cmd_q;
        buf_data_d  = buf_data_q;
        served_d    = served_q;
        if (pop) begin
            act_valid_d = 1'b1;
            act_cmd_d   = fifo_cmd_q[rd_ptr_q];
            act_cnt_d   = fifo_rpt_q[rd_ptr_q];
        end else if (act_last) begin
            act_valid_d = 1'b0;
        end else if (accept) begin
            act_cnt_d = act_cnt_q - RPT_WIDTH'(1);
        end
        if (accept) begin
            buf_valid_d = 1'b1;
            buf_cmd_d   = act_cmd_q;
            buf_data_d  = i_data_bus;
            served_d    = 2'b00;
        end else if (buf_done) begin
            buf_valid_d = 1'b0;
            served_d    = 2'b00;
        end else begin
            served_d = served_q | acc;
        end
        if (buf_valid_d)      state_d = ST_BUSY;
        else if (act_valid_d) state_d = ST_ARMED;
        else                  state_d = ST_IDLE;
    end

    // Control registers; everything in flight is discarded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            act_valid_q <= 1'b0;
            act_cmd_q   <= '0;
            act_cnt_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_cmd_q   <= '0;
            buf_data_q  <= '0;
            served_q    <= 2'b00;
            state_q     <= ST_IDLE;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q     <= count_d;
            act_valid_q <= act_valid_d;
            act_cmd_q   <= act_cmd_d;
            act_cnt_q   <= act_cnt_d;
            buf_valid_q <= buf_valid_d;
            buf_cmd_q   <= buf_cmd_d;
            buf_data_q  <= buf_data_d;
            served_q    <= served_d;
            state_q     <= state_d;
        end
    end

    // FIFO payload storage needs no reset; only slots behind count_q are ever read
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cmd_q[wr_ptr_q] <= i_cfg_cmd;
            fifo_rpt_q[wr_ptr_q] <= i_cfg_rpt;
        end
    end

    // Output drive
    always_comb begin
        o_cfg_ready = !fifo_full;
        o_sw_valid  = buf_valid_q & (buf_cmd_q != 2'b00);
        o_sw_en     = o_sw_valid;
        o_sw_cmd    = sw_cmd;
        o_data_bus  = buf_data_q;
        o_busy      = act_valid_q | buf_valid_q | !fifo_empty;
        o_dbg_state = state_q;
    end

`ifdef DIST_SCHED_PERF_CNT_EN
    logic [15:0] cnt_low_q, cnt_high_q, cnt_stall_q;

    // Saturating activity counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_low_q   <= '0;
            cnt_high_q  <= '0;
            cnt_stall_q <= '0;
        end else begin
            if (acc[0] && cnt_low_q != 16'hFFFF) cnt_low_q <= cnt_low_q + 16'd1;
            if (acc[1] && cnt_high_q != 16'hFFFF) cnt_high_q <= cnt_high_q + 16'd1;
            if (buf_valid_q && !buf_done && cnt_stall_q != 16'hFFFF)
                cnt_stall_q <= cnt_stall_q + 16'd1;
        end
    end

    assign o_cnt_low   = cnt_low_q;
    assign o_cnt_high  = cnt_high_q;
    assign o_cnt_stall = cnt_stall_q;
`endif

endmodule

// File: tb/tb_distribute_1x2_cmd_sched.sv
// Directed bench for distribute_1x2_cmd_sched.
module tb_distribute_1x2_cmd_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_cfg_valid = 1'b0;
    logic        o_cfg_ready;
    logic [1:0]  i_cfg_cmd = 2'b00;
    logic [7:0]  i_cfg_rpt = 8'd0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_data_bus = 32'd0;
    logic        o_sw_en, o_sw_valid;
    logic [1:0]  o_sw_cmd;
    logic [31:0] o_data_bus;
    logic [1:0]  i_ready = 2'b11;
    logic        o_busy;
    logic [1:0]  o_dbg_state;
`ifdef DIST_SCHED_PERF_CNT_EN
    logic [15:0] o_cnt_low, o_cnt_high, o_cnt_stall;
    logic [15:0] low0, high0, stall0;
`endif

    int total = 0;
    int bad = 0;
    int good_beats;

    distribute_1x2_cmd_sched dut (
        .clk(clk), .rst_n(rst_n),
        .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_cmd(i_cfg_cmd), .i_cfg_rpt(i_cfg_rpt),
        .i_valid(i_valid), .o_ready(o_ready), .i_data_bus(i_data_bus),
        .o_sw_en(o_sw_en), .o_sw_valid(o_sw_valid), .o_sw_cmd(o_sw_cmd),
        .o_data_bus(o_data_bus), .i_ready(i_ready), .o_busy(o_busy),
`ifdef DIST_SCHED_PERF_CNT_EN
        .o_cnt_low(o_cnt_low), .o_cnt_high(o_cnt_high), .o_cnt_stall(o_cnt_stall),
`endif
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sw_en"}, 32'(o_sw_en), 32'd0);
        check({tag, "_sw_valid"}, 32'(o_sw_valid), 32'd0);
        check({tag, "_sw_cmd"}, 32'(o_sw_cmd), 32'd0);
        check({tag, "_ready"}, 32'(o_ready), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_cfg_ready"}, 32'(o_cfg_ready), 32'd1);
    endtask

    task automatic push_cmd(input logic [1:0] cmd, input logic [7:0] rpt);
        i_cfg_valid = 1'b1;
        i_cfg_cmd   = cmd;
        i_cfg_rpt   = rpt;
        tick();
        i_cfg_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        check_idle_outputs("rst");
        check("rst_data", o_data_bus, 32'd0);
        check("rst_state", 32'(o_dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: low branch, 4 beats, upstream valid raised before any command exists
        i_valid = 1'b1;
        i_data_bus = 32'hA0;
        i_ready = 2'b11;
        push_cmd(2'b01, 8'd3);
        check("s1_stall_no_act", 32'(o_ready), 32'd0);
        check("s1_busy_fifo", 32'(o_busy), 32'd1);
        tick();
        check("s1_armed_ready", 32'(o_ready), 32'd1);
        check("s1_armed_state", 32'(o_dbg_state), 32'd1);
        for (int k = 0; k < 4; k++) begin
            i_data_bus = 32'hA0 + 32'(k);
            tick();
            check("s1_cmd", 32'(o_sw_cmd), 32'h1);
            check("s1_valid", 32'(o_sw_valid), 32'd1);
            check("s1_data", o_data_bus, 32'hA0 + 32'(k));
            check("s1_ready_after", 32'(o_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        i_valid = 1'b0;
        tick();
        check("s1_end_busy", 32'(o_busy), 32'd0);
        check("s1_end_sw_en", 32'(o_sw_en), 32'd0);

        // 2: duplicate, low ready first then high
`ifdef DIST_SCHED_PERF_CNT_EN
        low0 = o_cnt_low; high0 = o_cnt_high; stall0 = o_cnt_stall;
`endif
        i_ready = 2'b01;
        push_cmd(2'b11, 8'd0);
        tick();
        i_valid = 1'b1;
        i_data_bus = 32'hBEEF;
        tick();
        i_valid = 1'b0;
        check("s2_c1_cmd", 32'(o_sw_cmd), 32'h3);
        check("s2_c1_data", o_data_bus, 32'hBEEF);
        check("s2_c1_ready", 32'(o_ready), 32'd0);
        tick();
        i_ready = 2'b10;
        check("s2_c2_cmd", 32'(o_sw_cmd), 32'h2);
        check("s2_c2_valid", 32'(o_sw_valid), 32'd1);
        tick();
        check("s2_clear_valid", 32'(o_sw_valid), 32'd0);
        check("s2_clear_busy", 32'(o_busy), 32'd0);
`ifdef DIST_SCHED_PERF_CNT_EN
        check("s6_cnt_low", 32'(o_cnt_low - low0), 32'd1);
        check("s6_cnt_high", 32'(o_cnt_high - high0), 32'd1);
        check("s6_cnt_stall", 32'(o_cnt_stall - stall0), 32'd1);
`endif

        // 3: drop two beats, then one to the high branch
        i_ready = 2'b11;
        push_cmd(2'b00, 8'd1);
        push_cmd(2'b10, 8'd0);
        check("s3_ready_drop", 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_data_bus = 32'd1;
        tick();
        check("s3_b1_en", 32'(o_sw_en), 32'd0);
        check("s3_b1_busy", 32'(o_busy), 32'd1);
        check("s3_b1_ready", 32'(o_ready), 32'd1);
        i_data_bus = 32'd2;
        tick();
        check("s3_b2_en", 32'(o_sw_en), 32'd0);
        check("s3_b2_ready", 32'(o_ready), 32'd1);
        i_data_bus = 32'd3;
        tick();
        i_valid = 1'b0;
        check("s3_b3_cmd", 32'(o_sw_cmd), 32'h2);
        check("s3_b3_en", 32'(o_sw_en), 32'd1);
        check("s3_b3_data", o_data_bus, 32'd3);
        tick();
        check("s3_end_busy", 32'(o_busy), 32'd0);

        // 4: five commands back-to-back fill act plus the 4-entry FIFO
        push_cmd(2'b01, 8'd0);
        check("s4_rdy1", 32'(o_cfg_ready), 32'd1);
        push_cmd(2'b10, 8'd0);
        check("s4_rdy2", 32'(o_cfg_ready), 32'd1);
        push_cmd(2'b11, 8'd0);
        check("s4_rdy3", 32'(o_cfg_ready), 32'd1);
        push_cmd(2'b01, 8'd0);
        check("s4_rdy4", 32'(o_cfg_ready), 32'd1);
        push_cmd(2'b10, 8'd0);
        check("s4_full", 32'(o_cfg_ready), 32'd0);
        // Offer a sixth command while full, in the same cycle as the first pop: it must be refused
        i_cfg_valid = 1'b1;
        i_cfg_cmd = 2'b11;
        i_valid = 1'b1;
        i_data_bus = 32'h40;
        tick();
        i_cfg_valid = 1'b0;
        check("s4_b0_cmd", 32'(o_sw_cmd), 32'h1);
        check("s4_slot_freed", 32'(o_cfg_ready), 32'd1);
        i_data_bus = 32'h41;
        tick();
        check("s4_b1_cmd", 32'(o_sw_cmd), 32'h2);
        i_data_bus = 32'h42;
        tick();
        check("s4_b2_cmd", 32'(o_sw_cmd), 32'h3);
        i_data_bus = 32'h43;
        tick();
        check("s4_b3_cmd", 32'(o_sw_cmd), 32'h1);
        i_data_bus = 32'h44;
        tick();
        check("s4_b4_cmd", 32'(o_sw_cmd), 32'h2);
        check("s4_b4_data", o_data_bus, 32'h44);
        check("s4_no_extra", 32'(o_ready), 32'd0);
        i_valid = 1'b0;
        tick();
        check("s4_end_busy", 32'(o_busy), 32'd0);

        // 5: reset in the middle of a half-served duplicate
        i_ready = 2'b01;
        push_cmd(2'b11, 8'd2);
        tick();
        i_valid = 1'b1;
        i_data_bus = 32'h55;
        tick();
        i_valid = 1'b0;
        check("s5_c1_cmd", 32'(o_sw_cmd), 32'h3);
        tick();
        check("s5_c2_cmd", 32'(o_sw_cmd), 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("s5_rst");
        check("s5_rst_data", o_data_bus, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        i_ready = 2'b11;
        tick();
        tick();
        check("s5_no_replay_valid", 32'(o_sw_valid), 32'd0);
        check("s5_no_replay_busy", 32'(o_busy), 32'd0);

        // 7: all-ones repeat covers 256 beats, then retires
        push_cmd(2'b01, 8'hFF);
        tick();
        good_beats = 0;
        i_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            i_data_bus = 32'(k);
            tick();
            if (o_sw_valid === 1'b1 && o_data_bus === 32'(k)) good_beats++;
        end
        i_valid = 1'b0;
        check("s7_beats", 32'(good_beats), 32'd256);
        check("s7_retired", 32'(o_ready), 32'd0);
        tick();
        check("s7_end_busy", 32'(o_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #200000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

endmodule
